// File: rtl/icache_set_assoc.sv
// N-way set-associative instruction cache: IFU fetch port in, AXI INCR burst refill out.
// Round-robin replacement with invalid-way preference, uncached bypass window, deferred fence.i flush.
module icache_set_assoc #(
    parameter int unsigned WAYS_DIG            = 1,
    parameter int unsigned SET_NUM_DIG         = 2,
    parameter int unsigned BLOCK_SIZE_WORD_DIG = 2,
    parameter logic [31:0] BYPASS_BASE         = 32'h1000_0000,
    parameter logic [31:0] BYPASS_MASK         = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] out_araddr,
    output logic        out_arvalid,
    input  logic        out_arready,
    output logic [7:0]  out_arlen,
    output logic [1:0]  out_arburst,
    input  logic [31:0] out_rdata,
    input  logic [1:0]  out_rresp,
    input  logic        out_rvalid,
    output logic        out_rready,
    input  logic        out_rlast,
    input  logic        fence_i,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss
);
    localparam int unsigned WAYS    = 1 << WAYS_DIG;
    localparam int unsigned SETS    = 1 << SET_NUM_DIG;
    localparam int unsigned WORDS   = 1 << BLOCK_SIZE_WORD_DIG;
    localparam int unsigned IDX_LSB = BLOCK_SIZE_WORD_DIG + 2;
    localparam int unsigned TAG_LSB = IDX_LSB + SET_NUM_DIG;
    localparam int unsigned TAG_W   = 32 - TAG_LSB;

    typedef enum logic [2:0] {IDLE, MISS_AR, MISS_R, BYP_AR, BYP_R, RESP} state_t;

    state_t                         state_q;
    logic [31:0]                    addr_q;
    logic [31:0]                    rdata_q;
    logic [1:0]                     resp_q;
    logic [1:0]                     err_q;
    logic [BLOCK_SIZE_WORD_DIG-1:0] beat_q;
    logic [WAYS_DIG-1:0]            victim_q;
    logic                           from_ptr_q;
    logic                           pending_q;
    logic [31:0]                    hit_cnt_q;
    logic [31:0]                    miss_cnt_q;
    logic [WAYS-1:0]                valid_q [SETS];
    logic [WAYS_DIG-1:0]            ptr_q   [SETS];
    logic [TAG_W-1:0]               tag_q   [WAYS][SETS];
    logic [31:0]                    data_q  [WAYS][SETS][WORDS];

    logic [BLOCK_SIZE_WORD_DIG-1:0] req_off, lat_off;
    logic [SET_NUM_DIG-1:0]         req_idx, lat_idx;
    logic [TAG_W-1:0]               req_tag, lat_tag;
    logic                           req_bypass;
    logic                           req_hit;
    logic [31:0]                    hit_word;
    logic [WAYS_DIG-1:0]            vict;
    logic                           vict_ptr;
    logic                           found_inv;
    logic [1:0]                     err_total;

    assign req_off    = ifu_araddr[IDX_LSB-1:2];
    assign req_idx    = ifu_araddr[TAG_LSB-1:IDX_LSB];
    assign req_tag    = ifu_araddr[31:TAG_LSB];
    assign req_bypass = (ifu_araddr & BYPASS_MASK) == BYPASS_BASE;
    assign lat_off    = addr_q[IDX_LSB-1:2];
    assign lat_idx    = addr_q[TAG_LSB-1:IDX_LSB];
    assign lat_tag    = addr_q[31:TAG_LSB];
    assign err_total  = err_q | out_rresp;

    // Tag lookup and victim choice: lowest invalid way wins, else the set's pointer.
    always_comb begin
        req_hit   = 1'b0;
        hit_word  = '0;
        vict      = ptr_q[req_idx];
        vict_ptr  = 1'b1;
        found_inv = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
                req_hit  = 1'b1;
                hit_word = data_q[w][req_idx][req_off];
            end
            if (!valid_q[req_idx][w] && !found_inv) begin
                found_inv = 1'b1;
                vict      = WAYS_DIG'(w);
                vict_ptr  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            resp_q     <= '0;
            err_q      <= '0;
            beat_q     <= '0;
            victim_q   <= '0;
            from_ptr_q <= 1'b0;
            pending_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            if (fence_i && state_q != IDLE)
                pending_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (fence_i || pending_q) begin
                        for (int unsigned s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                            ptr_q[s]   <= '0;
                        end
                        pending_q <= 1'b0;
                    end else if (ifu_arvalid) begin
                        addr_q <= ifu_araddr;
                        beat_q <= '0;
                        err_q  <= '0;
                        if (req_bypass) begin
                            state_q <= BYP_AR;
                        end else if (req_hit) begin
                            rdata_q   <= hit_word;
                            resp_q    <= '0;
                            hit_cnt_q <= hit_cnt_q + 32'd1;
                            state_q   <= RESP;
                        end else begin
                            victim_q   <= vict;
                            from_ptr_q <= vict_ptr;
                            miss_cnt_q <= miss_cnt_q + 32'd1;
                            state_q    <= MISS_AR;
                        end
                    end
                end
                MISS_AR: if (out_arready) state_q <= MISS_R;
                MISS_R: begin
                    if (out_rvalid) begin
                        if (beat_q == lat_off)
                            rdata_q <= out_rdata;
                        err_q  <= err_total;
                        beat_q <= beat_q + 1'b1;
                        if (out_rlast) begin
                            valid_q[lat_idx][victim_q] <= ~|err_total;
                            if (from_ptr_q)
                                ptr_q[lat_idx] <= ptr_q[lat_idx] + 1'b1;
                            resp_q  <= err_total;
                            state_q <= RESP;
                        end
                    end
                end
                BYP_AR: if (out_arready) state_q <= BYP_R;
                BYP_R: begin
                    if (out_rvalid) begin
                        rdata_q <= out_rdata;
                        resp_q  <= out_rresp;
                        state_q <= RESP;
                    end
                end
                RESP: if (ifu_rready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state_q == MISS_R && out_rvalid) begin
            data_q[victim_q][lat_idx][beat_q] <= out_rdata;
            if (out_rlast)
                tag_q[victim_q][lat_idx] <= lat_tag;
        end
    end

    assign ifu_arready = (state_q == IDLE) && !pending_q && !fence_i;
    assign ifu_rvalid  = (state_q == RESP);
    assign ifu_rdata   = rdata_q;
    assign ifu_rresp   = resp_q;
    assign out_arvalid = (state_q == MISS_AR) || (state_q == BYP_AR);
    assign out_araddr  = (state_q == BYP_AR) ? addr_q : {addr_q[31:IDX_LSB], {IDX_LSB{1'b0}}};
    assign out_arlen   = (state_q == BYP_AR) ? 8'd0 : 8'(WORDS - 1);
    assign out_arburst = 2'b01;
    assign out_rready  = (state_q == MISS_R) || (state_q == BYP_R);
    assign perf_hit    = hit_cnt_q;
    assign perf_miss   = miss_cnt_q;

endmodule

// File: doc/icache_set_assoc.md
# icache_set_assoc

Parametrised N-way set-associative instruction cache between the IFU fetch port and the AXI burst memory port; successor to the direct-mapped ICACHE. Adds per-set round-robin replacement with invalid-way preference, an uncached bypass window, error propagation from refill beats, deferred fence.i flush, and hit/miss performance counters. Refill uses one INCR burst per miss; the requested word is returned after the last beat.

## Interface
- WAYS_DIG, 1: log2 of ways per set (1 gives 2 ways).
- SET_NUM_DIG, 2: log2 of number of sets.
- BLOCK_SIZE_WORD_DIG, 2: log2 of 32-bit words per line (1..3).
- BYPASS_BASE, 32'h1000_0000: base of the uncached window.
- BYPASS_MASK, 32'hF000_0000: an address is uncached iff (addr & BYPASS_MASK) == BYPASS_BASE.
- Address split: offset = addr[BLOCK_SIZE_WORD_DIG+1:2], index = next SET_NUM_DIG bits, tag = the remaining upper bits.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ifu_araddr  in  32  fetch address, word aligned.
- ifu_arvalid  in  1  fetch request.
- ifu_arready  out  1  request accepted.
- ifu_rdata  out  32  instruction word.
- ifu_rresp  out  2  response code: OKAY=2'b00, or the error seen on refill.
- ifu_rvalid  out  1  response valid.
- ifu_rready  in  1  IFU accepts response.
- out_araddr  out  32  memory read address.
- out_arvalid  out  1  memory request.
- out_arready  in  1  memory accepts request.
- out_arlen  out  8  beats minus 1. Cached miss: 2^BLOCK_SIZE_WORD_DIG−1. Bypass: 0.
- out_arburst  out  2  constant 2'b01 (INCR).
- out_rdata  in  32  beat data.
- out_rresp  in  2  beat response.
- out_rvalid  in  1  beat valid.
- out_rready  out  1  beat accept.
- out_rlast  in  1  last beat.
- fence_i  in  1  invalidate all lines (one-cycle pulse or level).
- perf_hit  out  32  count of cached hits.
- perf_miss  out  32  count of cached misses.

## Operation
States:
- IDLE: ifu_arready = 1 and no flush pending and fence_i = 0.
  - Flush: if fence_i or a pending flush is set, clear all valid bits and all round-robin pointers in one cycle, then clear pending. Any arvalid in that cycle is not accepted.
  - On accept: latch the address.
    - Bypass address: go to BYP_AR.
    - Tag match in any valid way of the set: hit. Register the word, perf_hit++, go to RESP.
    - Otherwise: miss. perf_miss++, go to MISS_AR.
  - Victim selection at accept:
    - Use the lowest-numbered invalid way.
    - If every way is valid, use the set's round-robin pointer.
- MISS_AR: out_araddr = latched address with the offset and byte bits zeroed. On out_arready go to MISS_R.
- MISS_R: out_rready = 1. On each beat:
  - Write the beat to victim[index][beat_cnt].
  - When beat_cnt == offset, capture the beat into ifu_rdata.
  - OR the beat's out_rresp into err.
  - beat_cnt++.
  - On rlast: if err == 0, write the tag and set valid. If err != 0, leave the line invalid. Advance the set pointer by 1 (mod ways) only if the victim came from the pointer. Go to RESP.
- BYP_AR / BYP_R: single beat at the latched address, no allocation, data and rresp go directly to the response. Counters are not changed.
- RESP: ifu_rvalid = 1. ifu_rresp = OKAY for a hit, otherwise the error captured on refill. On ifu_rready go to IDLE.

Rules:
- fence_i seen outside IDLE sets the pending flag. The flush runs in the first IDLE cycle, after the in-flight fill completes and is returned.
- Two ways holding the same tag is impossible by construction: a line is allocated only on miss.

## Timing
- Reset values:
  - state = IDLE, all valid bits, pointers, pending flag and counters = 0.
  - ifu_arready = 1, ifu_rvalid = 0, ifu_rresp = 0.
  - out_arvalid = 0, out_rready = 0, out_arlen = 2^BLOCK_SIZE_WORD_DIG−1, out_arburst = 2'b01.
  - ifu_rdata is undefined until the first response.
- rst asserted mid-burst: return to IDLE next cycle. Remaining beats arriving with out_rready = 0 are ignored. All lines are invalid.
- Hit latency: request accepted at T, ifu_rvalid at T+1.
- Miss latency: out_arvalid at T+1. ifu_rvalid appears the cycle after the rlast beat.
- ifu_rvalid and ifu_rdata stay stable until ifu_rready. Back-to-back hits cost 2 cycles each.
- out_arvalid stays high until out_arready. out_araddr is stable throughout.
- Beats beyond rlast are not accepted. beat_cnt wraps naturally at the line size.

## Test plan
- Cold miss at 0x8000_0004 (defaults), burst 0xA0..0xA3 → one 4-beat burst at 0x8000_0000, rdata = 0xA1, perf_miss = 1. A refetch at 0x8000_000C hits at T+1 with 0xA3, perf_hit = 1.
- Conflict: 0x8000_0000, then 0x8000_0040, then 0x8000_0080 (same set 0) → 2nd fill goes to way 1, 3rd evicts way 0 via the pointer. 0x8000_0040 still hits; 0x8000_0000 misses.
- Bypass at 0x1000_0000 → arlen = 0, data returned, no allocation. Repeat → second memory request issued, counters unchanged.
- Refill with rresp = 2'b10 on beat 2 → ifu_rresp = 2'b10, line invalid. The next fetch to the same line misses again.
- fence_i asserted during MISS_R → the fill completes and is returned, flush happens in the next IDLE with arready = 0 that cycle. The prior hit address then misses.
- Back-to-back hits with ifu_rready held low 3 cycles → rvalid and rdata stable, no new request accepted until the handshake.
